// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface: FU result requests in, one-hot grant back,
// registered CDB broadcast out.
// Port summary: fu_* request/payload bundle (FU side), fu_grant, cdb_* broadcast.
// Modports: slave = arbiter view, master = FU/consumer view.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF_LEN
`define PRF_LEN 6
`endif
`ifndef ROB_LEN
`define ROB_LEN 5
`endif
`ifndef SD
`define SD
`endif

interface cdb_arbiter_if #(
    parameter int NUM_FU = 4
);
    localparam int IDX_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                fu_valid;
    logic [NUM_FU-1:0][`XLEN-1:0]     fu_value;
    logic [NUM_FU-1:0][`PRF_LEN-1:0]  fu_prf_idx;
    logic [NUM_FU-1:0][`ROB_LEN-1:0]  fu_rob_idx;
    logic [NUM_FU-1:0][`XLEN-1:0]     fu_PC;
    logic [NUM_FU-1:0]                fu_grant;

    logic                             cdb_valid;
    logic [`XLEN-1:0]                 cdb_value;
    logic [`PRF_LEN-1:0]              cdb_prf_idx;
    logic [`ROB_LEN-1:0]              cdb_rob_idx;
    logic [`XLEN-1:0]                 cdb_PC;
    logic [IDX_W-1:0]                 cdb_fu_idx;

    modport slave (
        input  fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC,
        output fu_grant,
        output cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC, cdb_fu_idx
    );

    modport master (
        output fu_valid, fu_value, fu_prf_idx, fu_rob_idx, fu_PC,
        input  fu_grant,
        input  cdb_valid, cdb_value, cdb_prf_idx, cdb_rob_idx, cdb_PC, cdb_fu_idx
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: picks one requesting FU per cycle and broadcasts its result on the CDB.
// Latency: grant is combinational in cycle t; the broadcast is registered and visible in t+1.
// Backpressure: un-granted FUs simply keep fu_valid high; squash/reset suppress all grants.
//
// Ports: clock, reset (sync, active-high), squash (flush), cdb (cdb_arbiter_if.slave).
// Build option: CDB_ROUND_ROBIN_EN defined -> round-robin with a rotating priority
// pointer; undefined -> fixed priority, lowest FU index wins, no pointer state.
module cdb_arbiter #(
    parameter int NUM_FU = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.slave  cdb
);
    localparam int IDX_W = $clog2(NUM_FU);

    // Requests are masked here so neither a flush nor reset can ever produce a grant.
    logic [NUM_FU-1:0] req;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;

    assign req = (reset || squash) ? '0 : cdb.fu_valid;

`ifdef CDB_ROUND_ROBIN_EN
    localparam logic [IDX_W:0] NUM_FU_W = (IDX_W+1)'(NUM_FU);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   scan;

    // Scan upward from ptr; one extra bit on scan lets the modulo wrap work
    // for NUM_FU values that are not powers of two.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan >= NUM_FU_W) begin
                scan = scan - NUM_FU_W;
            end
            if (!gnt_any && req[scan[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[IDX_W-1:0];
            end
        end
    end

    // Winner gets lowest priority next time; pointer only moves on a real grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_FU-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= `SD '0;
        end else begin
            ptr_q <= `SD ptr_d;
        end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        cdb.fu_grant = '0;
        if (gnt_any) begin
            cdb.fu_grant[gnt_idx] = 1'b1;
        end
    end

    // Broadcast registers: payload holds when nothing is granted, only valid drops.
    logic                cdb_valid_q,   cdb_valid_d;
    logic [`XLEN-1:0]    cdb_value_q,   cdb_value_d;
    logic [`PRF_LEN-1:0] cdb_prf_idx_q, cdb_prf_idx_d;
    logic [`ROB_LEN-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [`XLEN-1:0]    cdb_PC_q,      cdb_PC_d;
    logic [IDX_W-1:0]    cdb_fu_idx_q,  cdb_fu_idx_d;

    always_comb begin
        cdb_valid_d   = gnt_any;
        cdb_value_d   = cdb_value_q;
        cdb_prf_idx_d = cdb_prf_idx_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_PC_d      = cdb_PC_q;
        cdb_fu_idx_d  = cdb_fu_idx_q;
        if (gnt_any) begin
            cdb_value_d   = cdb.fu_value[gnt_idx];
            cdb_prf_idx_d = cdb.fu_prf_idx[gnt_idx];
            cdb_rob_idx_d = cdb.fu_rob_idx[gnt_idx];
            cdb_PC_d      = cdb.fu_PC[gnt_idx];
            cdb_fu_idx_d  = gnt_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid_q   <= `SD 1'b0;
            cdb_value_q   <= `SD '0;
            cdb_prf_idx_q <= `SD '0;
            cdb_rob_idx_q <= `SD '0;
            cdb_PC_q      <= `SD '0;
            cdb_fu_idx_q  <= `SD '0;
        end else begin
            cdb_valid_q   <= `SD cdb_valid_d;
            cdb_value_q   <= `SD cdb_value_d;
            cdb_prf_idx_q <= `SD cdb_prf_idx_d;
            cdb_rob_idx_q <= `SD cdb_rob_idx_d;
            cdb_PC_q      <= `SD cdb_PC_d;
            cdb_fu_idx_q  <= `SD cdb_fu_idx_d;
        end
    end

    assign cdb.cdb_valid   = cdb_valid_q;
    assign cdb.cdb_value   = cdb_value_q;
    assign cdb.cdb_prf_idx = cdb_prf_idx_q;
    assign cdb.cdb_rob_idx = cdb_rob_idx_q;
    assign cdb.cdb_PC      = cdb_PC_q;
    assign cdb.cdb_fu_idx  = cdb_fu_idx_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios followed by random traffic,
// compared against a behavioural arbitration model.
module tb_cdb_arbiter;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset;
    logic squash;

    cdb_arbiter_if #(.NUM_FU(N)) bus ();

    cdb_arbiter #(.NUM_FU(N)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .cdb    (bus.slave)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int                  m_ptr;
    logic                m_valid;
    logic [`XLEN-1:0]    m_value;
    logic [`PRF_LEN-1:0] m_prf;
    logic [`ROB_LEN-1:0] m_rob;
    logic [`XLEN-1:0]    m_pc;
    int                  m_fu;

    // Stimulus payload per FU
    logic [`XLEN-1:0]    pv  [N];
    logic [`PRF_LEN-1:0] pp  [N];
    logic [`ROB_LEN-1:0] pr  [N];
    logic [`XLEN-1:0]    ppc [N];

    function automatic int pick(logic [N-1:0] v, int start);
        for (int off = 0; off < N; off++) begin
            automatic int i = (start + off) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            pv[i]  = $urandom;
            pp[i]  = `PRF_LEN'($urandom);
            pr[i]  = `ROB_LEN'($urandom);
            ppc[i] = $urandom;
        end
    endtask

    // One clock cycle: drive, check registered outputs of the previous edge and
    // the combinational grant, then advance the model across the next edge.
    task automatic cycle(logic [N-1:0] v, logic sq, logic rst);
        int g;
        int start;
        logic [N-1:0] eg;
        @(negedge clock);
        reset        = rst;
        squash       = sq;
        bus.fu_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.fu_value[i]   = pv[i];
            bus.fu_prf_idx[i] = pp[i];
            bus.fu_rob_idx[i] = pr[i];
            bus.fu_PC[i]      = ppc[i];
        end
        #1;
        chk("cdb_valid",   64'(bus.cdb_valid),   64'(m_valid));
        chk("cdb_value",   64'(bus.cdb_value),   64'(m_value));
        chk("cdb_prf_idx", 64'(bus.cdb_prf_idx), 64'(m_prf));
        chk("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(m_rob));
        chk("cdb_PC",      64'(bus.cdb_PC),      64'(m_pc));
        chk("cdb_fu_idx",  64'(bus.cdb_fu_idx),  64'(m_fu));
`ifdef CDB_ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        g  = (rst || sq) ? -1 : pick(v, start);
        eg = (g < 0) ? '0 : (N'(1) << g);
        chk("fu_grant", 64'(bus.fu_grant), 64'(eg));
        if (rst) begin
            m_valid = 1'b0; m_value = '0; m_prf = '0; m_rob = '0; m_pc = '0;
            m_fu = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_value = pv[g]; m_prf = pp[g]; m_rob = pr[g]; m_pc = ppc[g];
            m_fu    = g;
            m_ptr   = (g + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [N-1:0] rv;
        logic         rs;
        logic         rr;
        reset        = 1'b1;
        squash       = 1'b0;
        bus.fu_valid = '0;
        rand_payload();
        for (int i = 0; i < N; i++) begin
            bus.fu_value[i]   = pv[i];
            bus.fu_prf_idx[i] = pp[i];
            bus.fu_rob_idx[i] = pr[i];
            bus.fu_PC[i]      = ppc[i];
        end
        m_valid = 1'b0; m_value = '0; m_prf = '0; m_rob = '0; m_pc = '0;
        m_fu = 0; m_ptr = 0;
        @(posedge clock);

        // Reset held with requests present: no grant allowed
        cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        // Idle after reset
        repeat (3) cycle(4'b0000, 1'b0, 1'b0);

        // Single FU2 request with a known payload
        rand_payload();
        pv[2] = 32'h0000_00FF; pp[2] = `PRF_LEN'(5); pr[2] = `ROB_LEN'(3);
        cycle(4'b0100, 1'b0, 1'b0);
        rand_payload();
        cycle(4'b0000, 1'b0, 1'b0);

        // All FUs requesting for 8 cycles (FU2 already granted: pointer at 3)
        for (int c = 0; c < 8; c++) begin
            rand_payload();
            cycle(4'b1111, 1'b0, 1'b0);
        end

        // Put the pointer at 3 then request FU0 and FU3 (wrap-around case)
        rand_payload();
        cycle(4'b0100, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            rand_payload();
            cycle(4'b1001, 1'b0, 1'b0);
        end

        // Squash pulse while FU1 requests
        rand_payload();
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0);

        // Reset in the cycle a grant would happen; pointer must return to 0
        rand_payload();
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0110, 1'b0, 1'b1);
        rand_payload();
        cycle(4'b1111, 1'b0, 1'b0);
        // Squash and reset together
        cycle(4'b1111, 1'b1, 1'b1);
        cycle(4'b1010, 1'b0, 1'b0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rand_payload();
            rv = N'($urandom);
            rs = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 31) == 0);
            cycle(rv, rs, rr);
        end
        cycle(4'b0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 4, giving the number of functional-unit requesters (2..8).
REQ-002 The block SHALL use the codebase widths `XLEN, `PRF_LEN and `ROB_LEN, and the `SD delay on all register assignments.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named as below.
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- squash  input  1  mispredict flush; kills the broadcast in flight.
- fu_valid  input  NUM_FU  per-FU result-ready request.
- fu_value  input  NUM_FU x `XLEN  per-FU result value.
- fu_prf_idx  input  NUM_FU x `PRF_LEN  per-FU destination physical register.
- fu_rob_idx  input  NUM_FU x `ROB_LEN  per-FU ROB entry.
- fu_PC  input  NUM_FU x `XLEN  per-FU instruction PC.
- fu_grant  output  NUM_FU  one-hot grant, combinational; the FU drops its valid at the next edge.
- cdb_valid  output  1  registered broadcast valid.
- cdb_value  output  `XLEN  registered broadcast value.
- cdb_prf_idx  output  `PRF_LEN  registered broadcast tag.
- cdb_rob_idx  output  `ROB_LEN  registered broadcast ROB index.
- cdb_PC  output  `XLEN  registered broadcast PC.
- cdb_fu_idx  output  clog2(NUM_FU)  index of the FU owning the current broadcast.

Function
REQ-004 fu_grant SHALL be zero or one-hot, and nonzero iff any fu_valid bit is set and squash is 0.
REQ-005 fu_grant[i] SHALL be 1 only if fu_valid[i] is 1.
REQ-006 Granted-FU payload sampled in cycle t SHALL appear on cdb_* in cycle t+1, with cdb_valid=1 (latency 1).
REQ-007 A cycle with no grant SHALL produce cdb_valid=0 at t+1; cdb_value/prf/rob/PC/fu_idx SHALL hold their previous values.
REQ-008 Arbitration SHALL select the first requesting FU at or after priority pointer ptr, scanning upward modulo NUM_FU.
REQ-009 After a grant to FU i, ptr SHALL become (i+1) mod NUM_FU, wrapping from NUM_FU-1 to 0.
REQ-010 ptr SHALL hold its value in cycles with no grant.
REQ-011 A continuously requesting FU SHALL be granted within NUM_FU cycles, so no requester starves.
REQ-012 squash=1 SHALL force fu_grant=0 that cycle and cdb_valid=0 next cycle; ptr SHALL hold.
REQ-013 squash and reset asserted together SHALL behave as reset.
REQ-014 An FU keeping fu_valid high across a grant (back-to-back results) SHALL be treated as a new request, subject to REQ-008.

Reset
REQ-015 On reset the block SHALL set cdb_valid=0, cdb_value=0, cdb_prf_idx=0, cdb_rob_idx=0, cdb_PC=0, cdb_fu_idx=0 and ptr=0.
REQ-016 fu_grant SHALL be 0 during any cycle with reset=1.
REQ-017 Reset asserted mid-stream SHALL discard the pending grant; the first post-reset grant follows ptr=0.

Configuration
REQ-018 Macro CDB_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin per REQ-008..REQ-010.
REQ-019 Macro CDB_ROUND_ROBIN_EN undefined: arbitration SHALL be fixed priority, lowest index first, with ptr logic removed; REQ-011 is waived, and all other requirements still hold.

Verification
REQ-020 The bench SHALL cover these scenarios.
- Reset, then fu_valid=0000 for 3 cycles -> fu_grant=0000; cdb_valid=0 throughout; all cdb_* outputs 0.
- Single FU2 request, value 0x0000_00FF, prf 5, rob 3 -> fu_grant=0100 the same cycle; next cycle cdb_valid=1, value 0xFF, prf 5, rob 3, fu_idx 2.
- fu_valid=1111 held 8 cycles (round-robin) -> grants 0001,0010,0100,1000,0001,...; cdb_fu_idx 0,1,2,3,0,... delayed one cycle.
- ptr=3 with fu_valid=1001 -> FU3 granted, then FU0 (wrap-around); with CDB_ROUND_ROBIN_EN undefined -> FU0 granted every cycle.
- squash pulsed while FU1 requests -> fu_grant=0000 that cycle; cdb_valid=0 next cycle; FU1 granted the cycle after squash drops.
- Reset asserted in the same cycle as a grant -> no broadcast next cycle; ptr=0 afterwards.
